// File: rtl/axi_multi_arbiter_if.sv
// axi_if: AXI4 bundle shared by the arbiter and its masters.
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave  modport : drives AW/W/AR ready, B/R payload+valid
interface axi_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_multi_arbiter.sv
// axi_multi_arbiter: N-to-1 AXI arbiter. One master owns the external bus for
// exactly one complete transaction (write: AW/W/B, read: AR/R).
//   clk, rst_n    : clock, async active-low reset
//   m_axi         : outgoing AXI bus (master side)
//   s_axi[N]      : incoming per-master ports (0 = icache, 1 = dcache)
//   grant_o       : registered one-hot owner, zero when idle
//   busy_o        : a transaction is currently granted
module axi_multi_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int PRIORITY_MODE = 0,
    parameter int ID_W          = 4,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_if.master                  m_axi,
    axi_if.slave                   s_axi [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   busy_o
);
    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, GRANT_WR, GRANT_RD} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d, rr_ptr, rr_d, win;
    logic [NUM_MASTERS-1:0] grant_d;
    logic               wr_act, rd_act, done;

    // Flattened view of the per-master inputs so they can be indexed by owner.
    logic [NUM_MASTERS-1:0]                 s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, req;
    logic [NUM_MASTERS-1:0][ID_W-1:0]       s_awid, s_arid;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0]     s_awaddr, s_araddr;
    logic [NUM_MASTERS-1:0][7:0]            s_awlen, s_arlen;
    logic [NUM_MASTERS-1:0][2:0]            s_awsize, s_arsize;
    logic [NUM_MASTERS-1:0][1:0]            s_awburst, s_arburst;
    logic [NUM_MASTERS-1:0][DATA_W-1:0]     s_wdata;
    logic [NUM_MASTERS-1:0][DATA_W/8-1:0]   s_wstrb;
    logic [NUM_MASTERS-1:0]                 wr_own, rd_own;

    assign wr_act = (state_q == GRANT_WR);
    assign rd_act = (state_q == GRANT_RD);
    assign busy_o = (state_q != IDLE);
    assign req    = s_awvalid | s_arvalid;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
        assign s_awvalid[g] = s_axi[g].awvalid;
        assign s_awid[g]    = s_axi[g].awid;
        assign s_awaddr[g]  = s_axi[g].awaddr;
        assign s_awlen[g]   = s_axi[g].awlen;
        assign s_awsize[g]  = s_axi[g].awsize;
        assign s_awburst[g] = s_axi[g].awburst;
        assign s_wvalid[g]  = s_axi[g].wvalid;
        assign s_wdata[g]   = s_axi[g].wdata;
        assign s_wstrb[g]   = s_axi[g].wstrb;
        assign s_wlast[g]   = s_axi[g].wlast;
        assign s_bready[g]  = s_axi[g].bready;
        assign s_arvalid[g] = s_axi[g].arvalid;
        assign s_arid[g]    = s_axi[g].arid;
        assign s_araddr[g]  = s_axi[g].araddr;
        assign s_arlen[g]   = s_axi[g].arlen;
        assign s_arsize[g]  = s_axi[g].arsize;
        assign s_arburst[g] = s_axi[g].arburst;
        assign s_rready[g]  = s_axi[g].rready;

        assign wr_own[g] = wr_act & grant_o[g];
        assign rd_own[g] = rd_act & grant_o[g];

        // Non-owners see zeros on every response-side output.
        assign s_axi[g].awready = wr_own[g] & m_axi.awready;
        assign s_axi[g].wready  = wr_own[g] & m_axi.wready;
        assign s_axi[g].bvalid  = wr_own[g] & m_axi.bvalid;
        assign s_axi[g].bid     = wr_own[g] ? m_axi.bid   : '0;
        assign s_axi[g].bresp   = wr_own[g] ? m_axi.bresp : '0;
        assign s_axi[g].arready = rd_own[g] & m_axi.arready;
        assign s_axi[g].rvalid  = rd_own[g] & m_axi.rvalid;
        assign s_axi[g].rlast   = rd_own[g] & m_axi.rlast;
        assign s_axi[g].rid     = rd_own[g] ? m_axi.rid   : '0;
        assign s_axi[g].rdata   = rd_own[g] ? m_axi.rdata : '0;
        assign s_axi[g].rresp   = rd_own[g] ? m_axi.rresp : '0;
    end

    // Outgoing bus: owner's channels only, zero otherwise.
    assign m_axi.awvalid = wr_act & s_awvalid[owner_q];
    assign m_axi.awid    = wr_act ? s_awid[owner_q]    : '0;
    assign m_axi.awaddr  = wr_act ? s_awaddr[owner_q]  : '0;
    assign m_axi.awlen   = wr_act ? s_awlen[owner_q]   : '0;
    assign m_axi.awsize  = wr_act ? s_awsize[owner_q]  : '0;
    assign m_axi.awburst = wr_act ? s_awburst[owner_q] : '0;
    assign m_axi.wvalid  = wr_act & s_wvalid[owner_q];
    assign m_axi.wdata   = wr_act ? s_wdata[owner_q]   : '0;
    assign m_axi.wstrb   = wr_act ? s_wstrb[owner_q]   : '0;
    assign m_axi.wlast   = wr_act & s_wlast[owner_q];
    assign m_axi.bready  = wr_act & s_bready[owner_q];
    assign m_axi.arvalid = rd_act & s_arvalid[owner_q];
    assign m_axi.arid    = rd_act ? s_arid[owner_q]    : '0;
    assign m_axi.araddr  = rd_act ? s_araddr[owner_q]  : '0;
    assign m_axi.arlen   = rd_act ? s_arlen[owner_q]   : '0;
    assign m_axi.arsize  = rd_act ? s_arsize[owner_q]  : '0;
    assign m_axi.arburst = rd_act ? s_arburst[owner_q] : '0;
    assign m_axi.rready  = rd_act & s_rready[owner_q];

    // Only the final handshake of the transaction releases the grant.
    assign done = (wr_act & m_axi.bvalid & s_bready[owner_q])
                | (rd_act & m_axi.rvalid & m_axi.rlast & s_rready[owner_q]);

    // Winner search: scan from rr_ptr (round-robin) or from 0 (fixed priority),
    // wrapping explicitly so non-power-of-two counts never index past the end.
    always_comb begin
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (PRIORITY_MODE == 1) ? k : int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx]) begin
                win   = PTR_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_o <= '0;
            owner_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            grant_o <= grant_d;
            owner_q <= owner_d;
            rr_ptr  <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_o;
        owner_d = owner_q;
        rr_d    = rr_ptr;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    // Write first so a dirty write-back lands before the refill.
                    state_d      = s_awvalid[win] ? GRANT_WR : GRANT_RD;
                end
            end
            GRANT_WR, GRANT_RD: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = (owner_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_multi_arbiter.sv
module tb_axi_multi_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- main DUT: 3 masters, round-robin ----------------
    axi_if m_bus ();
    axi_if s_bus [N] ();
    logic [N-1:0] grant_o;
    logic         busy_o;

    axi_multi_arbiter #(.NUM_MASTERS(N), .PRIORITY_MODE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .m_axi(m_bus), .s_axi(s_bus),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    logic [N-1:0]       s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
    logic [N-1:0][31:0] s_awaddr, s_araddr, s_wdata;
    logic [N-1:0][3:0]  s_awid, s_arid;
    logic [N-1:0][7:0]  s_awlen, s_arlen;
    logic [N-1:0]       o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
    logic [N-1:0][31:0] o_rdata;
    logic [N-1:0][3:0]  o_bid, o_rid;

    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast;
    logic [3:0]  m_bid, m_rid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    for (genvar g = 0; g < N; g++) begin : g_s
        assign s_bus[g].awvalid = s_awvalid[g];
        assign s_bus[g].awid    = s_awid[g];
        assign s_bus[g].awaddr  = s_awaddr[g];
        assign s_bus[g].awlen   = s_awlen[g];
        assign s_bus[g].awsize  = 3'd2;
        assign s_bus[g].awburst = 2'b01;
        assign s_bus[g].wvalid  = s_wvalid[g];
        assign s_bus[g].wdata   = s_wdata[g];
        assign s_bus[g].wstrb   = 4'hF;
        assign s_bus[g].wlast   = s_wlast[g];
        assign s_bus[g].bready  = s_bready[g];
        assign s_bus[g].arvalid = s_arvalid[g];
        assign s_bus[g].arid    = s_arid[g];
        assign s_bus[g].araddr  = s_araddr[g];
        assign s_bus[g].arlen   = s_arlen[g];
        assign s_bus[g].arsize  = 3'd2;
        assign s_bus[g].arburst = 2'b01;
        assign s_bus[g].rready  = s_rready[g];
        assign o_awready[g] = s_bus[g].awready;
        assign o_wready[g]  = s_bus[g].wready;
        assign o_bvalid[g]  = s_bus[g].bvalid;
        assign o_bid[g]     = s_bus[g].bid;
        assign o_arready[g] = s_bus[g].arready;
        assign o_rvalid[g]  = s_bus[g].rvalid;
        assign o_rlast[g]   = s_bus[g].rlast;
        assign o_rid[g]     = s_bus[g].rid;
        assign o_rdata[g]   = s_bus[g].rdata;
    end

    assign m_bus.awready = m_awready;
    assign m_bus.wready  = m_wready;
    assign m_bus.bvalid  = m_bvalid;
    assign m_bus.bid     = m_bid;
    assign m_bus.bresp   = m_bresp;
    assign m_bus.arready = m_arready;
    assign m_bus.rvalid  = m_rvalid;
    assign m_bus.rlast   = m_rlast;
    assign m_bus.rid     = m_rid;
    assign m_bus.rresp   = m_rresp;
    assign m_bus.rdata   = m_rdata;

    // ---------------- second DUT: 2 masters, fixed priority ----------------
    axi_if m2_bus ();
    axi_if s2_bus [2] ();
    logic [1:0] grant2, fp_req, o2_arready;
    logic       busy2;

    axi_multi_arbiter #(.NUM_MASTERS(2), .PRIORITY_MODE(1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .m_axi(m2_bus), .s_axi(s2_bus),
        .grant_o(grant2), .busy_o(busy2)
    );

    for (genvar g = 0; g < 2; g++) begin : g_s2
        assign s2_bus[g].awvalid = 1'b0;
        assign s2_bus[g].awid    = '0;
        assign s2_bus[g].awaddr  = '0;
        assign s2_bus[g].awlen   = '0;
        assign s2_bus[g].awsize  = '0;
        assign s2_bus[g].awburst = '0;
        assign s2_bus[g].wvalid  = 1'b0;
        assign s2_bus[g].wdata   = '0;
        assign s2_bus[g].wstrb   = '0;
        assign s2_bus[g].wlast   = 1'b0;
        assign s2_bus[g].bready  = 1'b1;
        assign s2_bus[g].arvalid = fp_req[g];
        assign s2_bus[g].arid    = 4'(g);
        assign s2_bus[g].araddr  = 32'h100 * g;
        assign s2_bus[g].arlen   = '0;
        assign s2_bus[g].arsize  = 3'd2;
        assign s2_bus[g].arburst = 2'b01;
        assign s2_bus[g].rready  = 1'b1;
        assign o2_arready[g] = s2_bus[g].arready;
    end

    assign m2_bus.awready = 1'b0;
    assign m2_bus.wready  = 1'b0;
    assign m2_bus.bvalid  = 1'b0;
    assign m2_bus.bid     = '0;
    assign m2_bus.bresp   = '0;
    assign m2_bus.arready = 1'b1;
    assign m2_bus.rvalid  = 1'b1;
    assign m2_bus.rlast   = 1'b1;
    assign m2_bus.rid     = '0;
    assign m2_bus.rresp   = '0;
    assign m2_bus.rdata   = 32'h1234_5678;

    // ---------------- reference model (transaction level) ----------------
    // own = current owner (-1 when idle), own_wr = owner is doing a write.
    int own    = -1;
    bit own_wr = 1'b0;
    int rr     = 0;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int w;
        if (own < 0) begin
            w = pick(s_awvalid | s_arvalid, rr);
            if (w >= 0) begin
                own    = w;
                own_wr = s_awvalid[w];
            end
        end else if (own_wr ? (m_bvalid && s_bready[own])
                            : (m_rvalid && m_rlast && s_rready[own])) begin
            rr  = (own + 1) % N;
            own = -1;
        end
    endtask

    task automatic check_all();
        int o;
        bit wr, rd;
        logic [N-1:0] eg;
        o  = (own < 0) ? 0 : own;
        wr = (own >= 0) && own_wr;
        rd = (own >= 0) && !own_wr;
        eg = '0;
        if (own >= 0) eg[o] = 1'b1;
        chk("grant",     grant_o,       eg);
        chk("busy",      busy_o,        own >= 0);
        chk("m_awvalid", m_bus.awvalid, wr ? s_awvalid[o] : 1'b0);
        chk("m_awaddr",  m_bus.awaddr,  wr ? s_awaddr[o]  : 32'h0);
        chk("m_awid",    m_bus.awid,    wr ? s_awid[o]    : 4'h0);
        chk("m_wvalid",  m_bus.wvalid,  wr ? s_wvalid[o]  : 1'b0);
        chk("m_wdata",   m_bus.wdata,   wr ? s_wdata[o]   : 32'h0);
        chk("m_wlast",   m_bus.wlast,   wr ? s_wlast[o]   : 1'b0);
        chk("m_bready",  m_bus.bready,  wr ? s_bready[o]  : 1'b0);
        chk("m_arvalid", m_bus.arvalid, rd ? s_arvalid[o] : 1'b0);
        chk("m_araddr",  m_bus.araddr,  rd ? s_araddr[o]  : 32'h0);
        chk("m_arlen",   m_bus.arlen,   rd ? s_arlen[o]   : 8'h0);
        chk("m_rready",  m_bus.rready,  rd ? s_rready[o]  : 1'b0);
        for (int i = 0; i < N; i++) begin
            chk("s_awready", o_awready[i], (wr && o == i) ? m_awready : 1'b0);
            chk("s_wready",  o_wready[i],  (wr && o == i) ? m_wready  : 1'b0);
            chk("s_bvalid",  o_bvalid[i],  (wr && o == i) ? m_bvalid  : 1'b0);
            chk("s_bid",     o_bid[i],     (wr && o == i) ? m_bid     : 4'h0);
            chk("s_arready", o_arready[i], (rd && o == i) ? m_arready : 1'b0);
            chk("s_rvalid",  o_rvalid[i],  (rd && o == i) ? m_rvalid  : 1'b0);
            chk("s_rlast",   o_rlast[i],   (rd && o == i) ? m_rlast   : 1'b0);
            chk("s_rid",     o_rid[i],     (rd && o == i) ? m_rid     : 4'h0);
            chk("s_rdata",   o_rdata[i],   (rd && o == i) ? m_rdata   : 32'h0);
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are checked at negedge.
    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic clear();
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_awid = '0; s_arid = '0; s_awlen = '0; s_arlen = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
        m_bid = '0; m_rid = '0; m_bresp = '0; m_rresp = '0; m_rdata = '0;
    endtask

    // Finish whatever transaction is open and leave the arbiter idle.
    task automatic drain();
        s_awvalid = '0; s_arvalid = '0; s_wvalid = '0;
        s_bready = '1; s_rready = '1;
        m_bvalid = 1; m_rvalid = 1; m_rlast = 1;
        repeat (3) begin sample(); advance(); end
        clear();
        sample(); advance();
    endtask

    logic [N-1:0] exp_rr [13];
    int fp_cnt;

    initial begin
        exp_rr = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                   3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        rst_n  = 1'b0;
        fp_req = '0;
        clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_all();
        chk("rst_grant2", grant2, 2'b00);
        chk("rst_busy2",  busy2,  1'b0);
        rst_n = 1'b1;

        // Round-robin fairness, continuous single-beat reads (also 2 -> 0 wrap)
        s_arvalid = '1; s_rready = '1;
        for (int i = 0; i < N; i++) s_araddr[i] = 32'h1000 * (i + 1);
        m_arready = 1; m_rvalid = 1; m_rlast = 1;
        for (int c = 0; c < 13; c++) begin
            sample();
            chk("rr_order", grant_o, exp_rr[c]);
            advance();
        end
        drain();

        // Write-before-read from master 1 (rr_ptr is now 1)
        s_awvalid[1] = 1; s_arvalid[1] = 1; s_awlen[1] = 8'd7; s_awaddr[1] = 32'h2000;
        s_araddr[1] = 32'h3000; s_wdata[1] = 32'hDEAD_BEEF;
        m_awready = 1; m_wready = 1;
        sample(); advance();
        for (int b = 0; b < 8; b++) begin
            if (b == 1) s_awvalid[1] = 0;
            s_wvalid[1] = 1; s_wlast[1] = (b == 7);
            sample();
            chk("wbr_grant",   grant_o,       3'b010);
            chk("wbr_arvalid", m_bus.arvalid, 1'b0);
            chk("wbr_wdata",   m_bus.wdata,   32'hDEAD_BEEF);
            advance();
        end
        s_wvalid[1] = 0; s_wlast[1] = 0; m_bvalid = 1; s_bready[1] = 1;
        sample();
        chk("wbr_b_arvalid", m_bus.arvalid, 1'b0);
        chk("wbr_bvalid",    o_bvalid[1],   1'b1);
        advance();
        m_bvalid = 0; m_arready = 1;
        sample();
        chk("wbr_idle_grant", grant_o,      3'b000);
        chk("wbr_idle_arv",   m_bus.arvalid, 1'b0);
        advance();
        sample();
        chk("wbr_rd_grant",   grant_o,       3'b010);
        chk("wbr_rd_arvalid", m_bus.arvalid, 1'b1);
        advance();
        s_arvalid[1] = 0; s_rready[1] = 1; m_rvalid = 1; m_rlast = 1;
        sample(); advance();
        drain();

        // Burst lock: 16-beat read by master 0, master 1 requests at beat 3
        s_arvalid[0] = 1; s_araddr[0] = 32'h4000; s_arlen[0] = 8'd15; m_arready = 1;
        sample(); advance();
        sample();
        chk("burst_grant0", grant_o, 3'b001);
        advance();
        s_arvalid[0] = 0; s_rready[0] = 1;
        for (int b = 0; b < 16; b++) begin
            m_rvalid = 1; m_rlast = (b == 15); m_rdata = $urandom; m_rid = 4'(b);
            if (b == 3) begin s_arvalid[1] = 1; s_araddr[1] = 32'h5000; s_arlen[1] = 8'd3; end
            sample();
            chk("burst_rdata",    o_rdata[0],   m_rdata);
            chk("burst_grant",    grant_o,      3'b001);
            chk("burst_arready1", o_arready[1], 1'b0);
            advance();
        end
        m_rvalid = 0; m_rlast = 0;
        sample();
        chk("burst_idle", grant_o, 3'b000);
        advance();
        sample();
        chk("burst_next_grant", grant_o, 3'b010);
        advance();

        // Reset during beat 2 of master 1's 4-beat read
        s_arvalid[1] = 0; s_rready[1] = 1;
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1; m_rlast = 0; m_rdata = $urandom;
            sample(); advance();
        end
        m_rvalid = 1; m_rdata = 32'hCAFE_0002;
        rst_n = 1'b0;
        #1;
        chk("rstmid_grant",  grant_o,      3'b000);
        chk("rstmid_rready", m_bus.rready, 1'b0);
        chk("rstmid_rvalid", o_rvalid[1],  1'b0);
        chk("rstmid_busy",   busy_o,       1'b0);
        own = -1; rr = 0;
        @(posedge clk); #1;
        clear();
        rst_n = 1'b1;
        sample();
        chk("rstmid_idle", grant_o, 3'b000);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                s_awvalid[i] = ($urandom % 4) == 0;
                s_arvalid[i] = ($urandom % 3) == 0;
                s_wvalid[i]  = 1'($urandom);
                s_wlast[i]   = 1'($urandom);
                s_bready[i]  = 1'($urandom);
                s_rready[i]  = ($urandom % 4) != 0;
                s_awaddr[i]  = $urandom;
                s_araddr[i]  = $urandom;
                s_wdata[i]   = $urandom;
                s_awid[i]    = 4'($urandom);
                s_arid[i]    = 4'($urandom);
                s_awlen[i]   = 8'($urandom);
                s_arlen[i]   = 8'($urandom);
            end
            m_awready = 1'($urandom); m_wready = 1'($urandom); m_arready = 1'($urandom);
            m_bvalid  = ($urandom % 3) == 0;
            m_rvalid  = 1'($urandom);
            m_rlast   = ($urandom % 3) == 0;
            m_bid = 4'($urandom); m_rid = 4'($urandom); m_rdata = $urandom;
            sample(); advance();
        end
        drain();

        // Fixed priority: masters 0 and 1 request continuously
        fp_req = 2'b11;
        fp_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("fp_grant1",   grant2[1],     1'b0);
            chk("fp_arready1", o2_arready[1], 1'b0);
            if (grant2[0]) fp_cnt++;
            @(posedge clk); #1;
        end
        chk("fp_count0", fp_cnt, 6);
        fp_req = 2'b00;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
